// File: rtl/cmp_conv_pkg.sv
// Shared types and default parameters for the comparator conversion sequencer.
package cmp_conv_pkg;

   localparam int CNT_W_DEF      = 8;
   localparam int RST_CYCLES_DEF = 100;
   localparam int AVG_LOG2_DEF   = 2;

   typedef enum logic [1:0] {
      IDLE,
      DISCHARGE,
      INTEGRATE,
      OUTPUT
   } state_t;

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module cmp_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_ff;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_ff <= '0;
      else       r_ff <= {r_ff[0], i_d};
   end

   assign o_q = r_ff[1];

endmodule

// File: rtl/cmp_conv_ctrl.sv
// Comparator front-end sequencer: discharge, integrate, average, hand off.
// Define CMP_CONV_SYNC_EN to pass cmp through a two-flop synchronizer.
module cmp_conv_ctrl
   import cmp_conv_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int RST_CYCLES = RST_CYCLES_DEF,
   parameter int AVG_LOG2   = AVG_LOG2_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_cmp,
   output logic             o_ana_rst,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_result,
   output logic             o_result_valid,
   input  logic             i_result_ready,
   output logic             o_timeout
);

   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int IW    = AVG_LOG2 + 1;
   localparam int DW    = $clog2(RST_CYCLES) + 1;

   localparam logic [CNT_W-1:0] MAX      = '1;
   localparam logic [IW-1:0]    LAST_IDX = IW'((1 << AVG_LOG2) - 1);
   localparam logic [DW-1:0]    LAST_DIS = DW'(RST_CYCLES - 1);

   state_t             r_state;
   logic [DW-1:0]      r_dcnt;
   logic [CNT_W-1:0]   r_cnt;
   logic [IW-1:0]      r_idx;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ana_rst;
   logic               r_busy;
   logic [CNT_W-1:0]   r_result;
   logic               r_valid;
   logic               r_timeout;

   logic               w_cmp_s;
   logic               w_sat;
   logic               w_end;
   logic [ACC_W-1:0]   w_acc_nxt;

`ifdef CMP_CONV_SYNC_EN
   cmp_sync u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_cmp),
      .o_q   (w_cmp_s)
   );
`else
   assign w_cmp_s = i_cmp;
`endif

   // Sample always equals cnt: on saturation cnt is already MAX.
   assign w_sat     = (r_cnt == MAX);
   assign w_end     = w_cmp_s | w_sat;
   assign w_acc_nxt = r_acc + ACC_W'(r_cnt);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_dcnt    <= '0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_acc     <= '0;
         r_ana_rst <= 1'b1;
         r_busy    <= 1'b0;
         r_result  <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_ana_rst <= 1'b1;
               if (i_start) begin
                  r_acc     <= '0;
                  r_idx     <= '0;
                  r_timeout <= 1'b0;
                  r_dcnt    <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= DISCHARGE;
               end
            end
            DISCHARGE: begin
               if (r_dcnt == LAST_DIS) begin
                  r_cnt     <= '0;
                  r_ana_rst <= 1'b0;
                  r_state   <= INTEGRATE;
               end else begin
                  r_dcnt <= r_dcnt + DW'(1);
               end
            end
            INTEGRATE: begin
               if (w_end) begin
                  r_acc     <= w_acc_nxt;
                  r_ana_rst <= 1'b1;
                  if (!w_cmp_s) r_timeout <= 1'b1;
                  if (r_idx != LAST_IDX) begin
                     r_idx   <= r_idx + IW'(1);
                     r_dcnt  <= '0;
                     r_state <= DISCHARGE;
                  end else begin
                     r_result <= w_acc_nxt[AVG_LOG2 +: CNT_W];
                     r_valid  <= 1'b1;
                     r_state  <= OUTPUT;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            OUTPUT: begin
               if (i_result_ready) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_ana_rst      = r_ana_rst;
   assign o_busy         = r_busy;
   assign o_result       = r_result;
   assign o_result_valid = r_valid;
   assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_cmp_conv_ctrl.sv
// Scoreboard bench for cmp_conv_ctrl with randomized comparator timing.
module tb_cmp_conv_ctrl;

   localparam int CNT_W      = 4;
   localparam int RST_CYCLES = 4;
   localparam int AVG_LOG2   = 2;
   localparam int NS         = 1 << AVG_LOG2;
   localparam int MAX        = (1 << CNT_W) - 1;
`ifdef CMP_CONV_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic             clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_start = 1'b0;
   logic             i_cmp = 1'b0;
   logic             i_result_ready = 1'b0;
   logic             o_ana_rst;
   logic             o_busy;
   logic [CNT_W-1:0] o_result;
   logic             o_result_valid;
   logic             o_timeout;

   cmp_conv_ctrl #(
      .CNT_W      (CNT_W),
      .RST_CYCLES (RST_CYCLES),
      .AVG_LOG2   (AVG_LOG2)
   ) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_cmp          (i_cmp),
      .o_ana_rst      (o_ana_rst),
      .o_busy         (o_busy),
      .o_result       (o_result),
      .o_result_valid (o_result_valid),
      .i_result_ready (i_result_ready),
      .o_timeout      (o_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int res;
      int to;
   } res_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_len[$];
   res_t exp_res[$];
   int   dv[NS];

   task automatic chk(input bit ok, input string nm, input int act, input int req);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       return o_busy;
         1:       return o_ana_rst;
         default: return o_result_valid;
      endcase
   endfunction

   task automatic wait_for(input int w, input logic v, input int lim, input string nm);
      int n = 0;
      while (sig(w) != v && n < lim) begin
         tick();
         n++;
      end
      if (n >= lim) chk(1'b0, nm, n, lim);
   endtask

   // Reference: each sample is the cmp_s arrival index, capped at MAX.
   task automatic model(output int res, output int to);
      int sum = 0;
      to = 0;
      for (int i = 0; i < NS; i++) begin
         int eff;
         int s;
         eff = (dv[i] < 0) ? 100000 : dv[i] + LAT;
         if (eff <= MAX) s = eff;
         else begin
            s  = MAX;
            to = 1;
         end
         exp_len.push_back(s + 1);
         sum += s;
      end
      res = sum / NS;
   endtask

   task automatic do_conv(input int rdy_dly, input bit hold_start);
      int r;
      int t;
      model(r, t);
      exp_res.push_back('{res: r, to: t});
      wait_for(0, 1'b0, 200, "idle_wait");
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < NS; i++) begin
         int k = 0;
         wait_for(1, 1'b0, RST_CYCLES + 4, "integrate_wait");
         while (o_ana_rst == 1'b0 && k <= MAX + 3) begin
            if (dv[i] >= 0 && k == dv[i]) i_cmp = 1'b1;
            tick();
            k++;
         end
         i_cmp = 1'b0;
      end
      wait_for(2, 1'b1, 4, "valid_wait");
      if (hold_start) i_start = 1'b1;
      repeat (rdy_dly) tick();
      i_result_ready = 1'b1;
      tick();
      i_result_ready = 1'b0;
   endtask

   int               lo_run = 0;
   int               dis_run = 0;
   int               e_len;
   res_t             e_r;
   logic             p_valid = 1'b0;
   logic             p_ready = 1'b0;
   logic             p_xfer = 1'b0;
   logic             p_idle_start = 1'b0;
   logic             p_ana = 1'b1;
   logic [CNT_W-1:0] p_res = '0;
   logic             p_to = 1'b0;

   always @(negedge clk) begin
      if (i_rst) begin
         lo_run       = 0;
         dis_run      = 0;
         p_valid      = 1'b0;
         p_xfer       = 1'b0;
         p_idle_start = 1'b0;
         p_ana        = 1'b1;
      end else begin
         if (!o_ana_rst) lo_run++;
         else if (lo_run > 0) begin
            if (exp_len.size() == 0) chk(1'b0, "len_queue", lo_run, 0);
            else begin
               e_len = exp_len.pop_front();
               chk(lo_run == e_len, "integrate_len", lo_run, e_len);
            end
            lo_run = 0;
         end
         if (o_busy && o_ana_rst && !o_result_valid) dis_run++;
         else if (dis_run > 0) begin
            chk(dis_run == RST_CYCLES, "discharge_len", dis_run, RST_CYCLES);
            dis_run = 0;
         end
         if (p_valid && !p_ready)
            chk(o_result_valid && o_busy && o_result == p_res && o_timeout == p_to,
                "hold_stable", o_result, p_res);
         if (p_xfer)
            chk(!o_result_valid && !o_busy, "post_xfer_idle", {o_result_valid, o_busy}, 0);
         if (p_idle_start)
            chk(o_busy && o_ana_rst, "start_accept", {o_busy, o_ana_rst}, 3);
         if (o_result_valid && !p_valid)
            chk(!p_ana, "valid_latency", p_ana, 0);
         if (o_result_valid && i_result_ready) begin
            if (exp_res.size() == 0) chk(1'b0, "result_queue", o_result, 0);
            else begin
               e_r = exp_res.pop_front();
               chk(int'(o_result) == e_r.res, "result", o_result, e_r.res);
               chk(int'(o_timeout) == e_r.to, "timeout", o_timeout, e_r.to);
            end
         end
         p_valid      = o_result_valid;
         p_ready      = i_result_ready;
         p_xfer       = o_result_valid && i_result_ready;
         p_idle_start = !o_busy && i_start;
         p_ana        = o_ana_rst;
         p_res        = o_result;
         p_to         = o_timeout;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      chk(o_ana_rst == 1'b1, "rst_ana_rst", o_ana_rst, 1);
      chk(o_busy == 1'b0, "rst_busy", o_busy, 0);
      chk(o_result_valid == 1'b0, "rst_valid", o_result_valid, 0);
      chk(o_result == '0, "rst_result", o_result, 0);
      chk(o_timeout == 1'b0, "rst_timeout", o_timeout, 0);
      i_rst = 1'b0;
      tick();

      dv = '{10, 11, 12, 14};
      do_conv(0, 1'b0);
      dv = '{-1, -1, -1, -1};
      do_conv(2, 1'b0);
      dv = '{MAX - LAT, MAX - LAT, MAX - LAT, MAX - LAT};
      do_conv(20, 1'b1);
      dv = '{0, 1, 2, 3};
      do_conv(1, 1'b0);

      wait_for(0, 1'b0, 50, "abort_idle");
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      wait_for(1, 1'b0, RST_CYCLES + 4, "abort_integrate");
      repeat (3) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk(o_ana_rst == 1'b1, "abort_ana_rst", o_ana_rst, 1);
      chk(o_busy == 1'b0, "abort_busy", o_busy, 0);
      chk(o_result_valid == 1'b0, "abort_valid", o_result_valid, 0);
      chk(o_result == '0, "abort_result", o_result, 0);
      tick();
      dv = '{3, 5, 7, 9};
      do_conv(0, 1'b0);

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < NS; i++)
            dv[i] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, MAX + 2));
         do_conv(int'($urandom_range(0, 3)), (n < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      repeat (5) tick();
      chk(exp_res.size() == 0 && exp_len.size() == 0, "queues_drained",
          exp_res.size() + exp_len.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_conv_ctrl.md
# cmp_conv_ctrl

Sequencer for the comparator-based analog front end. Per conversion it holds the analog integrator in reset for a fixed time, releases it, and counts clock cycles until the comparator fires. It averages 2^AVG_LOG2 such samples and presents the result on a valid/ready output. It sits between the analog macro (`cmp` in, `ana_rst` out) and the digital readout logic.

## Interface
- CNT_W, 8: sample counter width; max sample value MAX = 2^CNT_W-1
- RST_CYCLES, 100: cycles `ana_rst` is held high before each integration, >=1
- AVG_LOG2, 2: log2 of samples averaged per result, 0..4
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; sampled only in IDLE; begins a conversion
- cmp  in  1  comparator output from the analog block
- ana_rst  out  1  integrator reset to the analog block, high = discharge
- busy  out  1  high in any state other than IDLE
- result  out  CNT_W  averaged cycle count
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- timeout  out  1  at least one sample in this result saturated; qualified by result_valid

## Operation
- States: IDLE, DISCHARGE, INTEGRATE, OUTPUT.
- Reset values: state IDLE, ana_rst=1, busy=0, result=0, result_valid=0, timeout=0. Internal counters and accumulator are 0.
- IDLE:
  - ana_rst=1.
  - If start=1, clear the accumulator, sample index and timeout, then go to DISCHARGE.
- DISCHARGE:
  - ana_rst=1 for exactly RST_CYCLES cycles.
  - Then go to INTEGRATE with cnt=0.
  - cmp is ignored.
- INTEGRATE: ana_rst=0. Each cycle, in priority order:
  - cmp_s=1: sample=cnt.
  - cnt==MAX: sample=MAX and set the timeout flag.
  - Otherwise cnt++.
- Sample end:
  - acc += sample. acc width is CNT_W+AVG_LOG2, so no overflow is possible.
  - If the sample index is below 2^AVG_LOG2-1, increment it and go to DISCHARGE.
  - Otherwise go to OUTPUT.
- OUTPUT:
  - result = acc >> AVG_LOG2, truncated.
  - result_valid=1; result and timeout are held stable.
  - When result_ready=1, go to IDLE with result_valid cleared.
  - result keeps its last value.
- cmp and saturation in the same cycle: cmp wins; timeout is not set.
- start outside IDLE is ignored. start held high causes back-to-back conversions.
- rst mid-conversion: return to the reset values next cycle. Any pending result is discarded.

## Timing
- Start accepted in cycle T (IDLE): DISCHARGE spans T+1..T+RST_CYCLES, and the first INTEGRATE cycle is T+RST_CYCLES+1.
- cmp_s high in the k-th INTEGRATE cycle (k counted from 0) gives sample=k.
- With AVG_LOG2=0, result_valid rises one cycle after the sample-end cycle.
- Transfer occurs on a cycle with result_valid & result_ready. IDLE is reached the next cycle, and a new start is accepted there.
- ana_rst, busy, result_valid and timeout are registered outputs.

## Configuration
- `CMP_CONV_SYNC_EN` defined: cmp passes through a two-flop synchronizer (cmp_s = cmp delayed 2 cycles). Samples read 2 higher for the same analog event.
- `CMP_CONV_SYNC_EN` undefined: cmp_s = cmp directly. cmp must already be synchronous to clk.

## Structure
- Package `cmp_conv_pkg`:
  - state enum typedef (IDLE, DISCHARGE, INTEGRATE, OUTPUT)
  - default parameter constants
- Sub-module `cmp_sync`: two-flop synchronizer, with reset to 0. Instantiated only under `CMP_CONV_SYNC_EN`.
- Single FSM with a DISCHARGE counter, INTEGRATE counter, sample index and accumulator.

## Test plan
All scenarios use RST_CYCLES=4 and macro undefined unless noted.
- AVG_LOG2=0, CNT_W=8: start pulse at cycle 0, cmp high at cycle 15 -> ana_rst low cycles 5..15, result=10, result_valid at 16, timeout=0.
- AVG_LOG2=2: cmp after 10, 11, 12, 14 INTEGRATE cycles -> result=11 (47>>2), four ana_rst high phases of 4 cycles each.
- cmp never asserted, CNT_W=4, AVG_LOG2=0 -> sample saturates at 15, result=15, timeout=1. cmp arriving exactly at cnt=15 -> result=15, timeout=0.
- result_ready held low 20 cycles -> result/result_valid/timeout stable, start ignored. Ready pulse -> IDLE next cycle; start held high -> DISCHARGE the cycle after.
- rst asserted during INTEGRATE -> next cycle ana_rst=1, busy=0, result_valid=0. A later conversion is unaffected by the aborted samples.
- `CMP_CONV_SYNC_EN` defined, first scenario repeated -> result=12.
